rv0_exu_m: RTL and testbench

- Integer multiply/divide execution unit (RV M extension, XLEN-wide ops only), sits directly downstream of the instruction decode unit.
- Consumes the EXU_M skid-buffer output: instruction, rs1 data, rs2 data.
- Computes the result iteratively: radix-2 shift-add multiply, restoring divide. Holds the result until the integer write-back arbiter grants it, then writes rd once, which releases the decode-stage reservation counter.
- One operation in flight; no internal queue.

---
 rtl/rv0_pkg.sv | 45 ++++
 rtl/rv0_mdu_dp.sv | 97 +++++++++
 rtl/rv0_exu_m.sv | 104 ++++++++++
 tb/tb_rv0_exu_m.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv0_pkg.sv
// Shared types and constants for the rv0 integer core: M-extension op encodings,
// MDU sequencer states and execution-unit identifiers.
package rv0_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        EXU_ALU,
        EXU_BRU,
        EXU_LSU,
        EXU_M,
        EXU_CSR
    } exu_type_e;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_WB
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    endfunction

    function automatic logic op_rs1_signed(input mdu_op_e op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op_rs2_signed(input mdu_op_e op);
        return op inside {MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/rv0_mdu_dp.sv
// Iterative multiply/divide datapath: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sharing one 2*XLEN accumulator, with sign fixup.
module rv0_mdu_dp
    import rv0_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            special_o,
    output logic [XLEN-1:0] special_res_o,
    output logic [XLEN-1:0] result_o
);

    mdu_op_e             op_in;
    mdu_op_e             op_q;
    logic                s1_neg, s2_neg;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf;
    logic                neg_res_q, neg_rem_q;
    logic [XLEN-1:0]     opnd_q;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN+1:0]     div_diff;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem;

    assign op_in  = mdu_op_e'(op_i);
    assign s1_neg = op_rs1_signed(op_in) && a_i[XLEN-1];
    assign s2_neg = op_rs2_signed(op_in) && b_i[XLEN-1];
    assign mag_a  = s1_neg ? -a_i : a_i;
    assign mag_b  = s2_neg ? -b_i : b_i;

    assign div_zero  = op_is_div(op_in) && (b_i == '0);
    assign div_ovf   = (op_in inside {MDU_DIV, MDU_REM}) &&
                       (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    assign special_o = div_zero || div_ovf;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        special_res_o = '0;
        unique case (op_in)
            MDU_DIV, MDU_DIVU: special_res_o = div_zero ? '1 : a_i;
            MDU_REM, MDU_REMU: special_res_o = div_zero ? a_i : '0;
            default:           special_res_o = '0;
        endcase
    end

    // Multiply: acc = {partial sum, multiplier}; divide: acc = {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

    always_comb begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        if (op_is_div(op_q)) begin
            if (div_diff[XLEN+1])
                acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            else
                acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // NOTE: pure datapath registers carry no reset; the sequencer never reads them before a load.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            op_q      <= op_in;
            neg_res_q <= s1_neg ^ s2_neg;
            neg_rem_q <= s1_neg;
            opnd_q    <= op_is_div(op_in) ? mag_b : mag_a;
            acc_q     <= {{XLEN{1'b0}}, op_is_div(op_in) ? mag_a : mag_b};
        end else if (step_i) begin
            acc_q <= acc_d;
        end
    end

    assign prod = neg_res_q ? -acc_q : acc_q;
    assign quo  = acc_q[XLEN-1:0];
    assign rem  = acc_q[2*XLEN-1:XLEN];

    always_comb begin
        result_o = '0;
        unique case (op_q)
            MDU_MUL:                        result_o = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: result_o = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              result_o = neg_res_q ? -quo : quo;
            MDU_REM, MDU_REMU:              result_o = neg_rem_q ? -rem : rem;
            default:                        result_o = '0;
        endcase
    end

endmodule

// File: rtl/rv0_exu_m.sv
// M-extension execution unit: accepts one op from decode, sequences the iterative
// datapath, and holds the result on the write-back port until the arbiter grants it.
module rv0_exu_m
    import rv0_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_rdy_i,
    output logic            in_ack_o,
    input  logic [31:0]     in_insn_i,
    input  logic [XLEN-1:0] in_idata1_i,
    input  logic [XLEN-1:0] in_idata2_i,
    output logic            wb_we_o,
    output logic [4:0]      wb_waddr_o,
    output logic [XLEN-1:0] wb_wdata_o,
    input  logic            wb_gnt_i,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN);

    mdu_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [4:0]      rd_q;
    logic [4:0]      in_rd;
    logic            accept;
    logic            load_wb;
    logic            dp_special;
    logic [XLEN-1:0] dp_special_res;
    logic [XLEN-1:0] dp_result;
    logic            unused_insn;

    // Only funct3 and rd matter; decode has already steered this op here.
    assign unused_insn = ^{in_insn_i[31:15], in_insn_i[6:0]};
    assign in_rd       = in_insn_i[11:7];

    assign in_ack_o = (state_q == ST_IDLE) && !flush_i;
    assign accept   = in_rdy_i && in_ack_o;
    assign wb_we_o  = (state_q == ST_WB);
    assign busy_o   = (state_q != ST_IDLE);

    rv0_mdu_dp #(
        .XLEN(XLEN)
    ) u_dp (
        .clk_i        (clk_i),
        .load_i       (accept),
        .step_i       (state_q == ST_CALC),
        .op_i         (in_insn_i[14:12]),
        .a_i          (in_idata1_i),
        .b_i          (in_idata2_i),
        .special_o    (dp_special),
        .special_res_o(dp_special_res),
        .result_o     (dp_result)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)
                         state_d = !dp_special ? ST_CALC :
                                   (in_rd == 5'd0) ? ST_IDLE : ST_WB;
            ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
            ST_FIX:  state_d = (rd_q == 5'd0) ? ST_IDLE : ST_WB;
            ST_WB:   if (wb_gnt_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    // The write-back register loads only on entry to WB and then holds until granted.
    assign load_wb = (state_d == ST_WB) && (state_q != ST_WB);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            rd_q       <= '0;
            wb_waddr_o <= '0;
            wb_wdata_o <= '0;
        end else begin
            if (accept) begin
                cnt_q <= CW'(XLEN - 1);
                rd_q  <= in_rd;
            end else if (state_q == ST_CALC && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (load_wb) begin
                wb_waddr_o <= (state_q == ST_IDLE) ? in_rd : rd_q;
                wb_wdata_o <= (state_q == ST_IDLE) ? dp_special_res : dp_result;
            end
        end
    end

endmodule

// File: tb/tb_rv0_exu_m.sv
// Directed bench for rv0_exu_m (XLEN=32): hand-computed M-extension results,
// latency, write-back stall, flush, reset and rd=x0 behaviour.
module tb_rv0_exu_m;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_rdy_i = 1'b0;
    logic        in_ack_o;
    logic [31:0] in_insn_i = '0;
    logic [31:0] in_idata1_i = '0;
    logic [31:0] in_idata2_i = '0;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        wb_gnt_i = 1'b1;
    logic        busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    rv0_exu_m #(.XLEN(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .in_rdy_i   (in_rdy_i),
        .in_ack_o   (in_ack_o),
        .in_insn_i  (in_insn_i),
        .in_idata1_i(in_idata1_i),
        .in_idata2_i(in_idata2_i),
        .wb_we_o    (wb_we_o),
        .wb_waddr_o (wb_waddr_o),
        .wb_wdata_o (wb_wdata_o),
        .wb_gnt_i   (wb_gnt_i),
        .busy_o     (busy_o)
    );

    function automatic logic [31:0] mk_insn(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // Presents one op for a single accept edge; returns #1 after that edge (cycle 1).
    task automatic issue(input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        in_insn_i   = mk_insn(f3, rd);
        in_idata1_i = a;
        in_idata2_i = b;
        in_rdy_i    = 1'b1;
        @(posedge clk_i); #1;
        in_rdy_i    = 1'b0;
    endtask

    // Waits (bounded) for wb_we_o; lat is the cycle count after the accept cycle.
    task automatic wait_we(output int lat);
        lat = 1;
        while (!wb_we_o && lat < 60) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        n_chk++; if (wb_we_o !== 1'b0) $display("FAIL reset_we: got %b want 0", wb_we_o); else n_pass++;
        n_chk++; if (wb_waddr_o !== 5'd0) $display("FAIL reset_waddr: got %h want 00", wb_waddr_o); else n_pass++;
        n_chk++; if (wb_wdata_o !== 32'd0) $display("FAIL reset_wdata: got %h want 00000000", wb_wdata_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
        n_chk++; if (in_ack_o !== 1'b1) $display("FAIL reset_ack: got %b want 1", in_ack_o); else n_pass++;
        @(posedge clk_i); #1;
    endtask

    task automatic test_mul_latency;
        int lat;
        wb_gnt_i = 1'b1;
        issue(F_MUL, 5'd5, 32'd7, 32'hFFFF_FFFD);
        wait_we(lat);
        n_chk++; if (lat !== 34) $display("FAIL mul_latency: got %0d want 34", lat); else n_pass++;
        n_chk++; if (wb_waddr_o !== 5'd5) $display("FAIL mul_waddr: got %0d want 5", wb_waddr_o); else n_pass++;
        n_chk++; if (wb_wdata_o !== 32'hFFFF_FFEB) $display("FAIL mul_wdata: got %h want ffffffeb", wb_wdata_o); else n_pass++;
        @(posedge clk_i); #1;
        n_chk++; if (wb_we_o !== 1'b0) $display("FAIL mul_we_one_cycle: got %b want 0", wb_we_o); else n_pass++;
        n_chk++; if (in_ack_o !== 1'b1) $display("FAIL mul_ack_after: got %b want 1", in_ack_o); else n_pass++;
    endtask

    task automatic test_mul_variants;
        logic [2:0]  f3 [0:2];
        logic [31:0] va [0:2];
        logic [31:0] vb [0:2];
        logic [31:0] ve [0:2];
        int lat;
        f3 = '{F_MULH, F_MULHU, F_MULHSU};
        va = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vb = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ve = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            issue(f3[i], 5'd10 + 5'(i), va[i], vb[i]);
            wait_we(lat);
            n_chk++;
            if (wb_we_o !== 1'b1 || wb_wdata_o !== ve[i])
                $display("FAIL mul_variant[%0d]: got we=%b data=%h want we=1 data=%h", i, wb_we_o, wb_wdata_o, ve[i]);
            else n_pass++;
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_div;
        logic [2:0]  f3 [0:4];
        logic [31:0] va [0:4];
        logic [31:0] vb [0:4];
        logic [31:0] ve [0:4];
        int lat;
        f3 = '{F_DIV, F_REM, F_DIVU, F_REMU, F_DIVU};
        va = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'hFFFF_FFFF};
        vb = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd3};
        ve = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'h5555_5555};
        for (int i = 0; i < 5; i++) begin
            issue(f3[i], 5'd20 + 5'(i), va[i], vb[i]);
            wait_we(lat);
            n_chk++;
            if (wb_we_o !== 1'b1 || lat !== 34 || wb_wdata_o !== ve[i])
                $display("FAIL div[%0d]: got we=%b lat=%0d data=%h want we=1 lat=34 data=%h", i, wb_we_o, lat, wb_wdata_o, ve[i]);
            else n_pass++;
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_special;
        logic [2:0]  f3 [0:5];
        logic [31:0] va [0:5];
        logic [31:0] vb [0:5];
        logic [31:0] ve [0:5];
        int lat;
        f3 = '{F_DIV, F_REM, F_DIVU, F_REMU, F_DIV, F_REM};
        va = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        vb = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ve = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 6; i++) begin
            issue(f3[i], 5'd1 + 5'(i), va[i], vb[i]);
            wait_we(lat);
            n_chk++;
            if (wb_we_o !== 1'b1 || lat !== 1 || wb_wdata_o !== ve[i] || wb_waddr_o !== 5'd1 + 5'(i))
                $display("FAIL special[%0d]: got we=%b lat=%0d rd=%0d data=%h want we=1 lat=1 rd=%0d data=%h",
                         i, wb_we_o, lat, wb_waddr_o, wb_wdata_o, i + 1, ve[i]);
            else n_pass++;
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_stall;
        int lat;
        wb_gnt_i = 1'b0;
        issue(F_MULHU, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_we(lat);
        n_chk++; if (wb_we_o !== 1'b1) $display("FAIL stall_we_rise: got %b want 1", wb_we_o); else n_pass++;
        in_insn_i   = mk_insn(F_DIV, 5'd3);
        in_idata1_i = 32'd5;
        in_idata2_i = 32'd0;
        in_rdy_i    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i); #1;
            n_chk++;
            if ({wb_we_o, wb_waddr_o, wb_wdata_o, in_ack_o, busy_o} !== {1'b1, 5'd9, 32'hFFFF_FFFE, 1'b0, 1'b1})
                $display("FAIL stall_hold[%0d]: got we=%b rd=%0d data=%h ack=%b busy=%b want 1/9/fffffffe/0/1",
                         c, wb_we_o, wb_waddr_o, wb_wdata_o, in_ack_o, busy_o);
            else n_pass++;
        end
        wb_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        wb_gnt_i = 1'b0;
        n_chk++;
        if (wb_we_o !== 1'b0 || in_ack_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL stall_after_gnt: got we=%b ack=%b busy=%b want 0/1/0", wb_we_o, in_ack_o, busy_o);
        else n_pass++;
        @(posedge clk_i); #1;
        in_rdy_i = 1'b0;
        n_chk++;
        if (wb_we_o !== 1'b1 || wb_waddr_o !== 5'd3 || wb_wdata_o !== 32'hFFFF_FFFF)
            $display("FAIL stall_next_accept: got we=%b rd=%0d data=%h want 1/3/ffffffff", wb_we_o, wb_waddr_o, wb_wdata_o);
        else n_pass++;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        n_chk++;
        if (wb_we_o !== 1'b0 || wb_waddr_o !== 5'd0 || wb_wdata_o !== 32'd0 || busy_o !== 1'b0)
            $display("FAIL reset_mid_wb: got we=%b rd=%0d data=%h busy=%b want 0/0/00000000/0",
                     wb_we_o, wb_waddr_o, wb_wdata_o, busy_o);
        else n_pass++;
        wb_gnt_i = 1'b1;
    endtask

    task automatic test_flush;
        int we_seen;
        wb_gnt_i = 1'b1;
        issue(F_MUL, 5'd6, 32'd3, 32'd4);
        repeat (5) @(posedge clk_i);
        #1;
        n_chk++; if (busy_o !== 1'b1) $display("FAIL flush_busy_before: got %b want 1", busy_o); else n_pass++;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        n_chk++;
        if (busy_o !== 1'b0 || wb_we_o !== 1'b0)
            $display("FAIL flush_to_idle: got busy=%b we=%b want 0/0", busy_o, wb_we_o);
        else n_pass++;
        we_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (wb_we_o === 1'b1) we_seen++;
            @(posedge clk_i); #1;
        end
        n_chk++; if (we_seen !== 0) $display("FAIL flush_no_wb: got %0d write cycles want 0", we_seen); else n_pass++;
        in_insn_i   = mk_insn(F_DIV, 5'd7);
        in_idata1_i = 32'd5;
        in_idata2_i = 32'd0;
        in_rdy_i    = 1'b1;
        flush_i     = 1'b1;
        #1;
        n_chk++; if (in_ack_o !== 1'b0) $display("FAIL flush_ack_low: got %b want 0", in_ack_o); else n_pass++;
        @(posedge clk_i); #1;
        flush_i  = 1'b0;
        in_rdy_i = 1'b0;
        n_chk++;
        if (busy_o !== 1'b0 || wb_we_o !== 1'b0)
            $display("FAIL flush_no_accept: got busy=%b we=%b want 0/0", busy_o, wb_we_o);
        else n_pass++;
    endtask

    task automatic test_rd0;
        logic b33, b34;
        int   we_seen;
        b33 = 1'b0;
        b34 = 1'b1;
        we_seen = 0;
        issue(F_DIVU, 5'd0, 32'd100, 32'd7);
        for (int c = 1; c <= 40; c++) begin
            if (c == 33) b33 = busy_o;
            if (c == 34) b34 = busy_o;
            if (wb_we_o === 1'b1) we_seen++;
            @(posedge clk_i); #1;
        end
        n_chk++; if (b33 !== 1'b1) $display("FAIL rd0_busy_fix: got %b want 1", b33); else n_pass++;
        n_chk++; if (b34 !== 1'b0) $display("FAIL rd0_busy_drop: got %b want 0", b34); else n_pass++;
        n_chk++; if (we_seen !== 0) $display("FAIL rd0_no_wb: got %0d write cycles want 0", we_seen); else n_pass++;
        issue(F_DIV, 5'd0, 32'd5, 32'd0);
        n_chk++;
        if (busy_o !== 1'b0 || wb_we_o !== 1'b0)
            $display("FAIL rd0_special: got busy=%b we=%b want 0/0", busy_o, wb_we_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat;
        wb_gnt_i = 1'b1;
        issue(F_REMU, 5'd4, 32'd100, 32'd7);
        wait_we(lat);
        n_chk++;
        if (wb_we_o !== 1'b1 || wb_waddr_o !== 5'd4 || wb_wdata_o !== 32'd2)
            $display("FAIL b2b_first: got we=%b rd=%0d data=%h want 1/4/00000002", wb_we_o, wb_waddr_o, wb_wdata_o);
        else n_pass++;
        @(posedge clk_i); #1;
        n_chk++; if (in_ack_o !== 1'b1) $display("FAIL b2b_ack: got %b want 1", in_ack_o); else n_pass++;
        issue(F_DIVU, 5'd8, 32'd100, 32'd7);
        wait_we(lat);
        n_chk++;
        if (wb_we_o !== 1'b1 || lat !== 34 || wb_waddr_o !== 5'd8 || wb_wdata_o !== 32'd14)
            $display("FAIL b2b_second: got we=%b lat=%0d rd=%0d data=%h want 1/34/8/0000000e",
                     wb_we_o, lat, wb_waddr_o, wb_wdata_o);
        else n_pass++;
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_mul_latency;
        test_mul_variants;
        test_div;
        test_special;
        test_stall;
        test_flush;
        test_rd0;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
